lsu_mem_initiator: RTL and testbench

Synthesizable load/store initiator sitting between the single-cycle core's execute stage and the memory port. It accepts one load or store at a time from the core, issues it to memory over a valid/ready request channel, waits for a response, and returns a size-adjusted, optionally sign-extended load value. It drives the same 64-bit memory space the simulation memory bridge serves, from the requesting side, with byte masks replacing the fixed 8-byte write length.

---
 rtl/lsu_mem_initiator.sv | 190 +++++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one core op at a time onto a valid/ready memory port.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned ops instead of truncating).
module lsu_mem_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iReq,
  input  logic        iWrEn,
  input  logic [63:0] iAddr,
  input  logic [63:0] iWrData,
  input  logic [1:0]  iSize,
  input  logic        iSignExt,
  output logic        oBusy,
  output logic        oDone,
  output logic [63:0] oRdData,
  output logic        oTimeout,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        oMisalign,
`endif
  output logic        oMemValid,
  input  logic        iMemReady,
  output logic [63:0] oMemAddr,
  output logic        oMemWrEn,
  output logic [63:0] oMemWrData,
  output logic [7:0]  oMemWrMask,
  input  logic        iMemRespValid,
  input  logic [63:0] iMemRdData
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic [7:0]  mask_q, mask_d;
  logic [2:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        wr_en_q, wr_en_d;
  logic        sext_q, sext_d;
  logic        done_q, done_d;
  logic        tout_q, tout_d;
  logic [31:0] cnt_q, cnt_d;

  // Incoming op decode: natural-alignment mask and the lane offset it implies
  logic [2:0] align_mask;
  logic [2:0] req_off;
  logic [7:0] size_mask;
  always_comb begin
    align_mask = 3'b000;
    size_mask  = 8'h01;
    case (iSize)
      2'd0:    begin align_mask = 3'b000; size_mask = 8'h01; end
      2'd1:    begin align_mask = 3'b001; size_mask = 8'h03; end
      2'd2:    begin align_mask = 3'b011; size_mask = 8'h0F; end
      default: begin align_mask = 3'b111; size_mask = 8'hFF; end
    endcase
    req_off = iAddr[2:0] & ~align_mask;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  logic misaligned;
  assign misaligned = |(iAddr[2:0] & align_mask);
`endif

  // Load return path: move the addressed lane down, then extend
  logic [63:0] shifted;
  logic [63:0] ext;
  always_comb begin
    shifted = iMemRdData >> {off_q, 3'b000};
    case (size_q)
      2'd0:    ext = {{56{sext_q & shifted[7]}},  shifted[7:0]};
      2'd1:    ext = {{48{sext_q & shifted[15]}}, shifted[15:0]};
      2'd2:    ext = {{32{sext_q & shifted[31]}}, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mask_d  = mask_q;
    off_d   = off_q;
    size_d  = size_q;
    wr_en_d = wr_en_q;
    sext_d  = sext_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    tout_d  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (iReq) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned) begin
            mis_d = 1'b1;
          end else begin
`else
          begin
`endif
            addr_d  = {iAddr[63:3], 3'b000};
            wdata_d = iWrData << {req_off, 3'b000};
            mask_d  = iWrEn ? (size_mask << req_off) : 8'h00;
            off_d   = req_off;
            size_d  = iSize;
            wr_en_d = iWrEn;
            sext_d  = iSignExt;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (iMemReady) begin
          state_d = RESP;
          cnt_d   = 32'd0;
        end
      end
      RESP: begin
        // A response arriving on the final timeout cycle still completes normally
        if (iMemRespValid) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (!wr_en_q) rdata_d = ext;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TIMEOUT_CYCLES - 1) begin
          state_d = IDLE;
          tout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mask_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      wr_en_q <= 1'b0;
      sext_q  <= 1'b0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mask_q  <= mask_d;
      off_q   <= off_d;
      size_q  <= size_d;
      wr_en_q <= wr_en_d;
      sext_q  <= sext_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
      cnt_q   <= cnt_d;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign oBusy      = (state_q != IDLE);
  assign oMemValid  = (state_q == REQ);
  assign oDone      = done_q;
  assign oTimeout   = tout_q;
  assign oRdData    = rdata_q;
  assign oMemAddr   = addr_q;
  assign oMemWrEn   = wr_en_q;
  assign oMemWrData = wdata_q;
  assign oMemWrMask = mask_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign oMisalign  = mis_q;
`endif

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Randomized scoreboard bench for lsu_mem_initiator; byte-level reference model.
module tb_lsu_mem_initiator;
  localparam int TO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        iReq, iWrEn, iSignExt, iMemReady, iMemRespValid;
  logic [63:0] iAddr, iWrData, iMemRdData;
  logic [1:0]  iSize;
  logic        oBusy, oDone, oTimeout, oMemValid, oMemWrEn;
  logic [63:0] oRdData, oMemAddr, oMemWrData;
  logic [7:0]  oMemWrMask;
  logic        mis_pulse;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .iClock(clk), .iReset(rst), .iReq(iReq), .iWrEn(iWrEn), .iAddr(iAddr),
    .iWrData(iWrData), .iSize(iSize), .iSignExt(iSignExt), .oBusy(oBusy),
    .oDone(oDone), .oRdData(oRdData), .oTimeout(oTimeout),
`ifdef LSU_MISALIGN_TRAP_EN
    .oMisalign(mis_pulse),
`endif
    .oMemValid(oMemValid), .iMemReady(iMemReady), .oMemAddr(oMemAddr),
    .oMemWrEn(oMemWrEn), .oMemWrData(oMemWrData), .oMemWrMask(oMemWrMask),
    .iMemRespValid(iMemRespValid), .iMemRdData(iMemRdData)
  );
`ifndef LSU_MISALIGN_TRAP_EN
  assign mis_pulse = 1'b0;
`endif

  typedef struct { int kind; logic [63:0] rd; int at; } rsp_t; // kind: 0 done, 1 timeout, 2 misalign
  typedef struct { logic [63:0] addr; logic we; logic [63:0] wd; logic [7:0] mask; } req_t;
  rsp_t rsp_q[$];
  req_t req_q[$];

  int total = 0, bad = 0;
  int cyc = 0;
  logic [63:0] last_rd = '0;
  int cur_rdy = 0, cur_rsp = 0;
  bit cur_noresp = 0;
  logic [63:0] cur_raw = '0;
  int ph = 0, wc = 0, rc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] load_ref(logic [63:0] raw, int offe, int nb, bit sx);
    logic [63:0] v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = raw[8*(offe+i) +: 8];
    if (sx && v[8*nb-1]) for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // Memory side: ready after cur_rdy valid cycles, response after cur_rsp RESP cycles
  initial begin
    forever begin
      @(negedge clk);
      iMemReady = 1'b0;
      iMemRespValid = 1'b0;
      iMemRdData = {$urandom, $urandom};
      if (rst) ph = 0;
      else if (ph == 2) begin
        if (rc == cur_rsp) begin
          if (!cur_noresp) begin iMemRespValid = 1'b1; iMemRdData = cur_raw; end
          ph = 0;
        end else rc++;
      end else if (oMemValid) begin
        if (ph == 0) begin ph = 1; wc = 0; end
        if (wc == cur_rdy) begin iMemReady = 1'b1; ph = 2; rc = 0; end
        else wc++;
      end else if (!oBusy && $urandom_range(0, 7) == 0) iMemRespValid = 1'b1;
    end
  end

  // Monitor: request fields every valid cycle, result/latency on every completion pulse
  initial begin
    bit prev_valid = 0;
    rsp_t r;
    int kind_now;
    forever begin
      @(negedge clk);
      if (rst) begin prev_valid = 0; continue; end
      if (oMemValid) begin
        if (req_q.size() == 0) chk("unexpected_req", {63'd0, oMemValid}, 64'd0);
        else begin
          chk("req_addr", oMemAddr, req_q[0].addr);
          chk("req_we", {63'd0, oMemWrEn}, {63'd0, req_q[0].we});
          chk("req_mask", {56'd0, oMemWrMask}, {56'd0, req_q[0].mask});
          if (req_q[0].we) chk("req_wdata", oMemWrData, req_q[0].wd);
        end
      end else if (prev_valid && req_q.size() > 0) void'(req_q.pop_front());
      prev_valid = oMemValid;
      if ({oDone, oTimeout, mis_pulse} != 3'b000) begin
        kind_now = oTimeout ? 1 : (mis_pulse ? 2 : 0);
        if ((oDone + oTimeout + mis_pulse) > 1) chk("multi_pulse", {61'd0, oDone, oTimeout, mis_pulse}, 64'd0);
        if (rsp_q.size() == 0) chk("unexpected_rsp", {61'd0, oDone, oTimeout, mis_pulse}, 64'd0);
        else begin
          r = rsp_q.pop_front();
          chk("rsp_kind", kind_now, r.kind);
          chk("rsp_cycle", cyc, r.at);
          chk("rsp_rdata", oRdData, r.rd);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    iReq = 1'b0;
    repeat (2) @(negedge clk);
    rsp_q.delete();
    req_q.delete();
    last_rd = '0;
    rst = 1'b0;
  endtask

  // Computes the expected request/result, queues them, then drives the op
  task automatic start(bit we, logic [63:0] addr, logic [63:0] wd, int sz, bit sx,
                       int rdy, int rsp, bit noresp, logic [63:0] raw);
    int nb, off, offe;
    bit mis;
    req_t q;
    rsp_t r;
    nb = 1 << sz;
    off = int'(addr[2:0]);
    mis = (off % nb) != 0;
    offe = off - (off % nb);
    if (TRAP && mis) begin
      r.kind = 2; r.at = cyc + 1; r.rd = last_rd;
    end else begin
      q.addr = addr & ~64'h7;
      q.we = we;
      q.wd = '0;
      for (int b = 0; b < 8; b++) if (b >= offe) q.wd[8*b +: 8] = wd[8*(b-offe) +: 8];
      q.mask = '0;
      if (we) for (int i = 0; i < nb; i++) q.mask[offe+i] = 1'b1;
      req_q.push_back(q);
      if (noresp) begin
        r.kind = 1; r.at = cyc + 2 + rdy + TO; r.rd = last_rd;
      end else begin
        if (!we) last_rd = load_ref(raw, offe, nb, sx);
        r.kind = 0; r.at = cyc + 3 + rdy + rsp; r.rd = last_rd;
      end
    end
    rsp_q.push_back(r);
    cur_rdy = rdy; cur_rsp = rsp; cur_noresp = noresp; cur_raw = raw;
    iReq = 1'b1; iWrEn = we; iAddr = addr; iWrData = wd; iSize = 2'(sz); iSignExt = sx;
    @(negedge clk);
    iReq = 1'b0;
    iAddr = {$urandom, $urandom}; iWrData = {$urandom, $urandom};
  endtask

  task automatic issue(bit we, logic [63:0] addr, logic [63:0] wd, int sz, bit sx,
                       int rdy, int rsp, bit noresp, logic [63:0] raw);
    int t = 0;
    start(we, addr, wd, sz, sx, rdy, rsp, noresp, raw);
    while (!(oDone || oTimeout || mis_pulse) && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) begin
      chk("completion_wait", 64'(t), 64'd0);
      do_reset();
    end
  endtask

  initial begin
    rst = 1'b1; iReq = 1'b0; iWrEn = 1'b0; iAddr = '0; iWrData = '0; iSize = '0; iSignExt = 1'b0;
    iMemReady = 1'b0; iMemRespValid = 1'b0; iMemRdData = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {63'd0, oBusy}, 64'd0);
    chk("rst_done", {63'd0, oDone}, 64'd0);
    chk("rst_timeout", {63'd0, oTimeout}, 64'd0);
    chk("rst_valid", {63'd0, oMemValid}, 64'd0);
    chk("rst_wren", {63'd0, oMemWrEn}, 64'd0);
    chk("rst_addr", oMemAddr, 64'd0);
    chk("rst_wdata", oMemWrData, 64'd0);
    chk("rst_rdata", oRdData, 64'd0);
    chk("rst_mask", {56'd0, oMemWrMask}, 64'd0);

    issue(0, 64'h80000008, 64'h0, 3, 0, 0, 0, 0, 64'h1122334455667788);
    issue(0, 64'h80000003, 64'h0, 0, 1, 0, 0, 0, 64'h00000000F0000000);
    issue(1, 64'h80000006, 64'hABCD, 1, 0, 0, 0, 0, 64'h0);
    issue(0, 64'h80000008, 64'h0, 3, 0, 4, 0, 0, 64'h1122334455667788);
    issue(0, 64'h80000010, 64'h0, 3, 0, 1, 0, 1, 64'h0);
    issue(0, 64'h80000002, 64'h0, 2, 0, 0, 0, 0, 64'h8877665544332211);
    issue(0, 64'h80000020, 64'h0, 2, 1, 0, 3, 0, 64'h00000000_80000001);

    for (int n = 0; n < 200; n++) begin
      issue($urandom_range(0, 1), 64'h80000000 + 64'($urandom_range(0, 255)),
            {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15) == 0,
            {$urandom, $urandom});
    end

    // Reset while a load is in flight: no completion, state and data cleared
    start(0, 64'h80000040, 64'h0, 3, 0, 3, 0, 1, 64'h0);
    @(negedge clk);
    do_reset();
    chk("midrst_busy", {63'd0, oBusy}, 64'd0);
    chk("midrst_valid", {63'd0, oMemValid}, 64'd0);
    chk("midrst_rdata", oRdData, 64'd0);
    repeat (10) @(negedge clk);
    issue(0, 64'h80000048, 64'h0, 3, 0, 0, 1, 0, 64'hCAFEF00DDEADBEEF);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end
endmodule
